// File: rtl/tdc_pkg.sv
// tdc_pkg: shared definitions for the multi-channel TDC stamper.
//   ENC_FIRST_ZERO / ENC_POPCOUNT : fine-time encoder selection codes.
//   fine_w(taps)                  : width of a fine code able to hold 0..taps.
//   tdc_event_t                   : event record {coarse, fine} at default widths
//                                   (COARSE_W=16, TAPS=32); the top builds the same
//                                   layout from its own parameters.
package tdc_pkg;

    localparam int ENC_FIRST_ZERO = 0;
    localparam int ENC_POPCOUNT   = 1;

    localparam int DEF_COARSE_W = 16;
    localparam int DEF_FINE_W   = 6;

    function automatic int fine_w(input int taps);
        return $clog2(taps) + 1;
    endfunction

    typedef struct packed {
        logic [DEF_COARSE_W-1:0] coarse;
        logic [DEF_FINE_W-1:0]   fine;
    } tdc_event_t;

endpackage

// File: rtl/tdc_chan_fifo.sv
// tdc_chan_fifo: per-channel synchronous event FIFO, count-based full/empty.
//   clk, rst        : clock, asynchronous active-high reset (pointers/count only)
//   push, push_data : write request and data; accepted when not full, or when
//                     full but popped in the same cycle
//   pop, pop_data   : read request; pop_data shows the head entry combinationally
//   full, empty     : occupancy flags
module tdc_chan_fifo
    import tdc_pkg::*;
#(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tdc_multi_stamper.sv
// tdc_multi_stamper: multi-channel carry-chain TDC sampler and event stamper.
//   clk_stop   : sampling/system clock
//   rst        : asynchronous active-high reset
//   enable     : low = no hits recorded and coarse counter frozen
//   taps_in    : raw delay-line taps, channel c at [c*TAPS +: TAPS]
//   out_valid/out_ready : merged event stream handshake
//   out_ch, out_coarse, out_fine : source channel, coarse stamp, fine code
//   drop_cnt   : per-channel 8-bit saturating count of events lost on FIFO full
module tdc_multi_stamper
    import tdc_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int TAPS       = 32,
    parameter  int COARSE_W   = 16,
    parameter  int FIFO_DEPTH = 8,
    parameter  int ENC_MODE   = ENC_POPCOUNT,
    localparam int FINE_W     = fine_w(TAPS),
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk_stop,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NUM_CH*TAPS-1:0] taps_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH_W-1:0]        out_ch,
    output logic [COARSE_W-1:0]    out_coarse,
    output logic [FINE_W-1:0]      out_fine,
    output logic [NUM_CH*8-1:0]    drop_cnt
);

    typedef struct packed {
        logic [COARSE_W-1:0] coarse;
        logic [FINE_W-1:0]   fine;
    } event_t;

    function automatic logic [FINE_W-1:0] enc_first_zero(input logic [TAPS-1:0] t);
        logic [FINE_W-1:0] n;
        logic              run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < TAPS; i++) begin
            run = run & t[i];
            if (run) n = n + FINE_W'(1);
        end
        return n;
    endfunction

    function automatic logic [FINE_W-1:0] enc_popcount(input logic [TAPS-1:0] t);
        return FINE_W'($countones(t));
    endfunction

    function automatic logic [FINE_W-1:0] encode(input logic [TAPS-1:0] t);
        return (ENC_MODE == ENC_FIRST_ZERO) ? enc_first_zero(t) : enc_popcount(t);
    endfunction

    logic [TAPS-1:0]     thermo_p0 [NUM_CH];
    logic [NUM_CH-1:0]   prev0_p0;
    logic [COARSE_W-1:0] coarse;
    logic [COARSE_W-1:0] coarse_p0;
    logic [NUM_CH-1:0]   hit_p1;
    logic [FINE_W-1:0]   fine_p1 [NUM_CH];
    logic [COARSE_W-1:0] coarse_p1;

    logic [NUM_CH-1:0]   push;
    logic [NUM_CH-1:0]   pop;
    logic [NUM_CH-1:0]   full;
    logic [NUM_CH-1:0]   empty;
    event_t              fifo_dout [NUM_CH];

    logic                load;
    logic                grant_any;
    logic [CH_W-1:0]     grant_idx;
    logic [CH_W-1:0]     rr_ptr;

    // S0: sample taps, remember previous bit 0, run coarse counter.
    // S1: rising edge of bit 0 while enabled is a hit.
    always_ff @(posedge clk_stop or posedge rst) begin
        if (rst) begin
            coarse   <= '0;
            prev0_p0 <= '0;
            hit_p1   <= '0;
            for (int c = 0; c < NUM_CH; c++) thermo_p0[c] <= '0;
        end else begin
            if (enable) coarse <= coarse + COARSE_W'(1);
            for (int c = 0; c < NUM_CH; c++) begin
                thermo_p0[c] <= taps_in[c*TAPS +: TAPS];
                prev0_p0[c]  <= thermo_p0[c][0];
                hit_p1[c]    <= thermo_p0[c][0] & ~prev0_p0[c] & enable;
            end
        end
    end

    // S1 data: fine code and coarse stamp travel one stage behind the sample.
    always_ff @(posedge clk_stop) begin
        coarse_p0 <= coarse;
        coarse_p1 <= coarse_p0;
        for (int c = 0; c < NUM_CH; c++) fine_p1[c] <= encode(thermo_p0[c]);
    end

    // S2: push hits into per-channel FIFOs, count drops.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        event_t     ev_in;
        logic       drop;
        logic [7:0] drop_q;

        assign ev_in   = {coarse_p1, fine_p1[c]};
        // A pop of a full FIFO in the same cycle frees the slot for the push.
        assign push[c] = hit_p1[c] & (~full[c] | pop[c]);
        assign drop    = hit_p1[c] & full[c] & ~pop[c];

        tdc_chan_fifo #(
            .WIDTH ($bits(event_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk_stop),
            .rst       (rst),
            .push      (push[c]),
            .push_data (ev_in),
            .pop       (pop[c]),
            .pop_data  (fifo_dout[c]),
            .full      (full[c]),
            .empty     (empty[c])
        );

        always_ff @(posedge clk_stop or posedge rst) begin
            if (rst) begin
                drop_q <= '0;
            end else if (drop && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end

        assign drop_cnt[c*8 +: 8] = drop_q;
    end

    // Round-robin search starts at rr_ptr (one past the last grant).
    assign load = ~out_valid | out_ready;

    always_comb begin
        int              k;
        logic [CH_W-1:0] idx;
        grant_any = 1'b0;
        grant_idx = '0;
        pop       = '0;
        k         = 0;
        idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NUM_CH) k = k - NUM_CH;
            idx = CH_W'(k);
            if (!grant_any && !empty[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
        if (load && grant_any) pop[grant_idx] = 1'b1;
    end

    // Output register: refilled whenever empty or consumed.
    always_ff @(posedge clk_stop or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_coarse <= '0;
            out_fine   <= '0;
            rr_ptr     <= '0;
        end else if (load) begin
            if (grant_any) begin
                out_valid  <= 1'b1;
                out_ch     <= grant_idx;
                out_coarse <= fifo_dout[grant_idx].coarse;
                out_fine   <= fifo_dout[grant_idx].fine;
                rr_ptr     <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdc_multi_stamper.sv
// tb_tdc_multi_stamper: two stamper instances sharing stimulus
//   dut_a : popcount encoder, 16-bit coarse counter
//   dut_b : first-zero encoder, 4-bit coarse counter
// A queue-based event model predicts both output streams and drop counters.
module tb_tdc_multi_stamper;

    localparam int NCH   = 4;
    localparam int TAPS  = 32;
    localparam int DEPTH = 8;

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b1;
    logic                 enable    = 1'b1;
    logic                 out_ready = 1'b1;
    logic [NCH*TAPS-1:0]  taps      = '0;

    logic        a_valid, b_valid;
    logic [1:0]  a_ch, b_ch;
    logic [15:0] a_coarse;
    logic [3:0]  b_coarse;
    logic [5:0]  a_fine, b_fine;
    logic [31:0] a_drop, b_drop;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    tdc_multi_stamper #(
        .NUM_CH(NCH), .TAPS(TAPS), .COARSE_W(16), .FIFO_DEPTH(DEPTH), .ENC_MODE(1)
    ) dut_a (
        .clk_stop(clk), .rst(rst), .enable(enable), .taps_in(taps),
        .out_valid(a_valid), .out_ready(out_ready), .out_ch(a_ch),
        .out_coarse(a_coarse), .out_fine(a_fine), .drop_cnt(a_drop)
    );

    tdc_multi_stamper #(
        .NUM_CH(NCH), .TAPS(TAPS), .COARSE_W(4), .FIFO_DEPTH(DEPTH), .ENC_MODE(0)
    ) dut_b (
        .clk_stop(clk), .rst(rst), .enable(enable), .taps_in(taps),
        .out_valid(b_valid), .out_ready(out_ready), .out_ch(b_ch),
        .out_coarse(b_coarse), .out_fine(b_fine), .drop_cnt(b_drop)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model index 0 follows dut_a, index 1 follows dut_b.
    int            q [2*NCH][$];
    int            m_ov [2];
    int            m_ch [2];
    int            m_co [2];
    int            m_fi [2];
    int            m_rr [2];
    int            m_coarse [2];
    int            m_cs1 [2];
    int            m_drop [2][NCH];
    int            pev [2][NCH];
    bit            phit [NCH];
    bit            s2b [NCH];
    logic [TAPS-1:0] s1 [NCH];

    function automatic int cmod(input int d);
        return (d == 0) ? 65536 : 16;
    endfunction

    function automatic int enc(input int d, input logic [TAPS-1:0] t);
        int n;
        if (d == 0) return $countones(t);
        n = 0;
        while (n < TAPS && t[n] == 1'b1) n++;
        return n;
    endfunction

    function automatic logic [31:0] drop_vec(input int d);
        logic [31:0] v;
        int          x;
        v = '0;
        for (int c = 0; c < NCH; c++) begin
            x = m_drop[d][c];
            v[c*8 +: 8] = x[7:0];
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2*NCH; i++) q[i].delete();
        for (int d = 0; d < 2; d++) begin
            m_ov[d] = 0; m_ch[d] = 0; m_co[d] = 0; m_fi[d] = 0;
            m_rr[d] = 0; m_coarse[d] = 0; m_cs1[d] = 0;
            for (int c = 0; c < NCH; c++) begin
                m_drop[d][c] = 0;
                pev[d][c]    = 0;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            phit[c] = 1'b0; s2b[c] = 1'b0; s1[c] = '0;
        end
    endtask

    task automatic model_step();
        bit found;
        int k;
        int e;
        for (int d = 0; d < 2; d++) begin
            // output register takes the next event in round-robin order
            if (m_ov[d] == 0 || out_ready) begin
                found = 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    k = (m_rr[d] + i) % NCH;
                    if (!found && q[d*NCH+k].size() > 0) begin
                        found    = 1'b1;
                        e        = q[d*NCH+k].pop_front();
                        m_ov[d]  = 1;
                        m_ch[d]  = k;
                        m_co[d]  = e >> 8;
                        m_fi[d]  = e & 255;
                        m_rr[d]  = (k + 1) % NCH;
                    end
                end
                if (!found) m_ov[d] = 0;
            end
            // hits decided one edge ago enter the queues (after this edge's pop)
            for (int c = 0; c < NCH; c++) begin
                if (phit[c]) begin
                    if (q[d*NCH+c].size() < DEPTH) q[d*NCH+c].push_back(pev[d][c]);
                    else if (m_drop[d][c] < 255) m_drop[d][c]++;
                end
            end
        end
        for (int c = 0; c < NCH; c++) begin
            phit[c] = s1[c][0] && !s2b[c] && enable;
            for (int d = 0; d < 2; d++) pev[d][c] = (m_cs1[d] << 8) | enc(d, s1[c]);
        end
        for (int c = 0; c < NCH; c++) begin
            s2b[c] = s1[c][0];
            s1[c]  = taps[c*TAPS +: TAPS];
        end
        for (int d = 0; d < 2; d++) begin
            m_cs1[d] = m_coarse[d];
            if (enable) m_coarse[d] = (m_coarse[d] + 1) % cmod(d);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_valid", a_valid, m_ov[0]);
            if (m_ov[0] != 0) begin
                chk("a_ch", a_ch, m_ch[0]);
                chk("a_coarse", a_coarse, m_co[0]);
                chk("a_fine", a_fine, m_fi[0]);
            end
            chk("a_drop", a_drop, drop_vec(0));
            chk("b_valid", b_valid, m_ov[1]);
            if (m_ov[1] != 0) begin
                chk("b_ch", b_ch, m_ch[1]);
                chk("b_coarse", b_coarse, m_co[1]);
                chk("b_fine", b_fine, m_fi[1]);
            end
            chk("b_drop", b_drop, drop_vec(1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int c, input logic [31:0] v);
        taps[c*TAPS +: TAPS] = v;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          waits;
        int          t3co;
        logic [31:0] w;
        logic        b;

        step(3);
        chk("rst_valid", a_valid, 0);
        chk("rst_ch", a_ch, 0);
        chk("rst_coarse", a_coarse, 0);
        chk("rst_fine", a_fine, 0);
        chk("rst_drop", a_drop, 0);
        chk("rst_b_valid", b_valid, 0);
        chk_en = 1'b1;
        rst    = 1'b0;

        // single level-held hit on ch0 sampled at edge 10
        step(10);
        set_ch(0, 32'h0000_00FF);
        step(3);
        chk("t1_not_yet", a_valid, 0);
        step(1);
        chk("t1_valid", a_valid, 1);
        chk("t1_ch", a_ch, 0);
        chk("t1_coarse", a_coarse, 10);
        chk("t1_fine", a_fine, 8);
        chk("t1_b_coarse", b_coarse, 10);
        chk("t1_b_fine", b_fine, 8);
        step(6);
        chk("t1_no_second", a_valid, 0);

        // bubble at bit 3 on ch3
        set_ch(3, 32'h0000_00F7);
        step(4);
        chk("t2_valid", a_valid, 1);
        chk("t2_ch", a_ch, 3);
        chk("t2_fine_pop", a_fine, 7);
        chk("t2_fine_fz", b_fine, 3);
        step(2);

        // all channels hit together
        taps = '0;
        step(2);
        t3co = m_coarse[0];
        taps = {NCH{32'h0000_00FF}};
        step(4);
        for (int i = 0; i < NCH; i++) begin
            chk("t3_valid", a_valid, 1);
            chk("t3_ch", a_ch, i);
            chk("t3_coarse", a_coarse, t3co);
            step(1);
        end
        taps = '0;
        step(2);
        set_ch(0, 32'h0000_00FF);
        set_ch(1, 32'h0000_00FF);
        step(4);
        chk("t3b_first", a_ch, 0);
        step(1);
        chk("t3b_second", a_ch, 1);
        step(3);
        chk("t3b_idle", a_valid, 0);
        taps = '0;
        step(2);

        // stalled consumer, 10 hits on ch2
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_ch(2, 32'h1);
            step(1);
            set_ch(2, 32'h0);
            step(1);
        end
        step(4);
        chk("t4_drop_a", a_drop[23:16], 1);
        chk("t4_drop_b", b_drop[23:16], 1);
        chk("t4_hold_ch", a_ch, 2);
        out_ready = 1'b1;
        n = 0;
        repeat (14) begin
            if (a_valid === 1'b1 && a_ch == 2) n++;
            step(1);
        end
        chk("t4_drained", n, 9);

        // coarse wrap on the 4-bit instance
        waits = 0;
        while (m_coarse[1] != 15 && waits < 40) begin
            step(1);
            waits++;
        end
        chk("t5_wait", m_coarse[1], 15);
        set_ch(0, 32'h1);
        step(1);
        set_ch(1, 32'h1);
        step(3);
        chk("t5_valid", b_valid, 1);
        chk("t5_ch0", b_ch, 0);
        chk("t5_coarse15", b_coarse, 15);
        step(1);
        chk("t5_ch1", b_ch, 1);
        chk("t5_coarse0", b_coarse, 0);
        taps = '0;
        step(3);

        // reset with buffered events
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_ch(3, 32'h1);
            step(1);
            set_ch(3, 32'h0);
            step(1);
        end
        step(4);
        chk("t6_pre_valid", a_valid, 1);
        chk("t6_pre_drop", a_drop, 32'h0001_0000);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", a_valid, 0);
        chk("t6_rst_drop", a_drop, 0);
        chk("t6_rst_b_valid", b_valid, 0);
        chk("t6_rst_b_drop", b_drop, 0);
        step(2);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("t6_no_stale", a_valid, 0);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom_range(0, 15) != 0);
            out_ready = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            for (int c = 0; c < NCH; c++) begin
                b = taps[c*TAPS];
                if ($urandom_range(0, 2) == 0) b = ~b;
                w    = $urandom();
                w[0] = b;
                set_ch(c, w);
            end
            step(1);
        end
        taps      = '0;
        enable    = 1'b1;
        out_ready = 1'b1;
        step(60);
        chk("final_idle", a_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
